// File: rtl/data_mem_responder.sv
// data_mem_responder
// Memory-side responder for load/store requests. Takes one request at a time,
// owns a word-organised synchronous data RAM, performs sub-word stores by
// read-modify-write and returns sign/zero-extended load data with an error flag.
module data_mem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e        state_q;
  logic          store_q;
  logic [2:0]    funct3_q;
  logic [1:0]    lane_q;
  logic [AW-1:0] index_q;
  logic [15:0]   wdataLow_q;
  logic [31:0]   writeWord_q;
  logic [31:0]   ramRead_q;
  logic [31:0]   respRdata_q;
  logic          respErr_q;

  logic [31:0]   mem_q [0:DEPTH-1];

  logic          reqFire;
  logic [AW-1:0] reqIndex;
  logic          reqErr;
  logic [7:0]    loadByte;
  logic [15:0]   loadHalf;
  logic [31:0]   loadData_d;
  logic [31:0]   mergeWord_d;

  // A request is illegal if its funct3 is not a defined load/store width,
  // if it is not naturally aligned, or if it falls outside the RAM window.
  function automatic logic requestError(input logic        isStore,
                                        input logic [2:0]  funct3,
                                        input logic [31:0] addr);
    logic illegal;
    logic misaligned;
    logic outOfRange;
    illegal    = isStore ? (funct3 > 3'd2)
                         : (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7);
    misaligned = (funct3[1:0] == 2'd1 && addr[0]) ||
                 (funct3[1:0] == 2'd2 && addr[1:0] != 2'b00);
    outOfRange = (addr < BASE_ADDR) ||
                 (((addr - BASE_ADDR) >> 2) >= 32'(DEPTH));
    return illegal | misaligned | outOfRange;
  endfunction

  // The request port is only open while idle and out of reset.
  assign req_ready  = rst_n && (state_q == IDLE);
  assign reqFire    = req_valid && req_ready;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = respRdata_q;
  assign resp_err   = respErr_q;

  // Decode the incoming request: RAM word index and error classification.
  always_comb begin
    reqIndex = AW'((req_addr - BASE_ADDR) >> 2);
    reqErr   = requestError(req_store, req_funct3, req_addr);
  end

  // Pick the addressed lane out of the word read from RAM and extend it.
  always_comb begin
    loadByte   = ramRead_q[{lane_q, 3'b000} +: 8];
    loadHalf   = lane_q[1] ? ramRead_q[31:16] : ramRead_q[15:0];
    loadData_d = 32'h0;
    case (funct3_q)
      3'd0:    loadData_d = {{24{loadByte[7]}}, loadByte};
      3'd1:    loadData_d = {{16{loadHalf[15]}}, loadHalf};
      3'd2:    loadData_d = ramRead_q;
      3'd4:    loadData_d = {24'h0, loadByte};
      3'd5:    loadData_d = {16'h0, loadHalf};
      default: loadData_d = 32'h0;
    endcase
  end

  // Build the word for a sub-word store: old word with the addressed lane replaced.
  always_comb begin
    mergeWord_d = ramRead_q;
    if (funct3_q[1:0] == 2'd0) begin
      mergeWord_d[{lane_q, 3'b000} +: 8] = wdataLow_q[7:0];
    end else begin
      mergeWord_d[{lane_q[1], 4'b0000} +: 16] = wdataLow_q;
    end
  end

  // Synchronous RAM: read addressed at accept so the word is ready in READ;
  // writes happen in WRITE and are dropped if reset is asserted that cycle.
  always_ff @(posedge clk) begin
    if (reqFire) begin
      ramRead_q <= mem_q[reqIndex];
    end
    if (rst_n && state_q == WRITE) begin
      mem_q[index_q] <= writeWord_q;
    end
  end

  // Control FSM: accept, optional read and/or write, then hold the response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      store_q     <= 1'b0;
      funct3_q    <= 3'd0;
      lane_q      <= 2'd0;
      index_q     <= '0;
      wdataLow_q  <= 16'h0;
      writeWord_q <= 32'h0;
      respRdata_q <= 32'h0;
      respErr_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            store_q     <= req_store;
            funct3_q    <= req_funct3;
            lane_q      <= req_addr[1:0];
            index_q     <= reqIndex;
            wdataLow_q  <= req_wdata[15:0];
            writeWord_q <= req_wdata;
            respRdata_q <= 32'h0;
            respErr_q   <= reqErr;
            if (reqErr) begin
              state_q <= RESP;
            end else if (req_store && req_funct3 == 3'd2) begin
              state_q <= WRITE;
            end else begin
              state_q <= READ;
            end
          end
        end
        READ: begin
          if (store_q) begin
            writeWord_q <= mergeWord_d;
            state_q     <= WRITE;
          end else begin
            respRdata_q <= loadData_d;
            state_q     <= RESP;
          end
        end
        WRITE: begin
          state_q <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
// Drives directed and randomized load/store requests into data_mem_responder
// and compares responses, latency and handshake behaviour against a byte-level
// reference memory model.
module tb_data_mem_responder;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic [7:0]  refMem [0:4*DEPTH-1];
  int          checkCount = 0;
  int          passCount  = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_store(req_store),
    .req_funct3(req_funct3),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
  endtask

  // Byte-addressed memory model: error rules, little-endian access, extension.
  function automatic void refModel(input logic st, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wd,
                                   output logic err, output logic [31:0] rd,
                                   output int lat);
    int   size;
    int   off;
    logic illegal;
    logic misal;
    logic oor;
    illegal = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
    size    = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    misal   = (addr % size) != 0;
    oor     = (addr < BASE) || ((addr - BASE) / 4 >= DEPTH);
    err     = illegal || misal || oor;
    rd      = 32'h0;
    if (err) begin
      lat = 1;
    end else begin
      off = int'(addr - BASE);
      if (st) begin
        for (int i = 0; i < size; i++) refMem[off + i] = wd[8*i +: 8];
        lat = (size == 4) ? 2 : 3;
      end else begin
        for (int i = 0; i < size; i++) rd = rd | (32'(refMem[off + i]) << (8 * i));
        if (f3 < 3'd4 && size < 4 && rd[8*size-1]) rd = rd | (32'hFFFF_FFFF << (8 * size));
        lat = 2;
      end
    end
  endfunction

  // One complete transaction, with an optional number of backpressure cycles.
  task automatic applyStimulus(input string tag, input logic st, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input int hold);
    logic        expErr;
    logic [31:0] expRd;
    int          expLat;
    int          lat;
    refModel(st, f3, addr, wd, expErr, expRd, expLat);
    @(negedge clk);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    checkOutput($sformatf("%s/accept_ready", tag), 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    checkOutput($sformatf("%s/latency", tag), 32'(lat), 32'(expLat));
    if (hold > 0) begin
      req_valid  = 1'b1;
      req_store  = 1'b0;
      req_funct3 = 3'd2;
      req_addr   = BASE;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        checkOutput($sformatf("%s/stall_valid", tag), 32'(resp_valid), 32'd1);
        checkOutput($sformatf("%s/stall_rdata", tag), resp_rdata, expRd);
        checkOutput($sformatf("%s/stall_ready", tag), 32'(req_ready), 32'd0);
      end
    end
    checkOutput($sformatf("%s/rdata", tag), resp_rdata, expRd);
    checkOutput($sformatf("%s/err", tag), 32'(resp_err), 32'(expErr));
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    checkOutput($sformatf("%s/done_valid", tag), 32'(resp_valid), 32'd0);
    checkOutput($sformatf("%s/done_ready", tag), 32'(req_ready), 32'd1);
  endtask

  // Accept a request, then pull reset for two cycles while it is in flight.
  task automatic resetDuringOp(input string tag, input logic st, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput($sformatf("%s/rst_ready", tag), 32'(req_ready), 32'd0);
    checkOutput($sformatf("%s/rst_valid", tag), 32'(resp_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput($sformatf("%s/post_valid", tag), 32'(resp_valid), 32'd0);
    checkOutput($sformatf("%s/post_ready", tag), 32'(req_ready), 32'd1);
    checkOutput($sformatf("%s/post_rdata", tag), resp_rdata, 32'h0);
    checkOutput($sformatf("%s/post_err", tag), 32'(resp_err), 32'd0);
  endtask

  initial begin
    logic [31:0] addr;
    logic        st;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset/ready", 32'(req_ready), 32'd0);
    checkOutput("reset/valid", 32'(resp_valid), 32'd0);
    checkOutput("reset/rdata", resp_rdata, 32'h0);
    checkOutput("reset/err", 32'(resp_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset/ready_after", 32'(req_ready), 32'd1);

    for (int w = 0; w < DEPTH; w++) begin
      applyStimulus("preload", 1'b1, 3'd2, BASE + 32'(4 * w), $urandom, 0);
    end

    applyStimulus("sw_10", 1'b1, 3'd2, 32'h10, 32'h1122_3344, 0);
    resetDuringOp("rst_read", 1'b0, 3'd2, 32'h10, 32'h0);
    applyStimulus("lw_10", 1'b0, 3'd2, 32'h10, 32'h0, 0);

    applyStimulus("sw_20", 1'b1, 3'd2, 32'h20, 32'hDEAD_BEEF, 0);
    applyStimulus("lw_20", 1'b0, 3'd2, 32'h20, 32'h0, 0);

    applyStimulus("sw_20z", 1'b1, 3'd2, 32'h20, 32'h0, 0);
    applyStimulus("sb_23", 1'b1, 3'd0, 32'h23, 32'h0000_0080, 0);
    applyStimulus("lb_23", 1'b0, 3'd0, 32'h23, 32'h0, 0);
    applyStimulus("lbu_23", 1'b0, 3'd4, 32'h23, 32'h0, 0);
    applyStimulus("lw_20b", 1'b0, 3'd2, 32'h20, 32'h0, 0);

    applyStimulus("sw_40", 1'b1, 3'd2, 32'h40, 32'h1234_5678, 0);
    applyStimulus("sh_42", 1'b1, 3'd1, 32'h42, 32'h0000_8001, 0);
    applyStimulus("lh_42", 1'b0, 3'd1, 32'h42, 32'h0, 0);
    applyStimulus("lhu_40", 1'b0, 3'd5, 32'h40, 32'h0, 0);
    applyStimulus("lw_40", 1'b0, 3'd2, 32'h40, 32'h0, 0);

    applyStimulus("err_lw21", 1'b0, 3'd2, 32'h21, 32'h0, 0);
    applyStimulus("err_sh43", 1'b1, 3'd1, 32'h43, 32'hFFFF_FFFF, 0);
    applyStimulus("err_lb_oor", 1'b0, 3'd0, BASE + 32'(4 * DEPTH), 32'h0, 0);
    applyStimulus("err_f3", 1'b0, 3'd3, 32'h40, 32'h0, 0);
    applyStimulus("err_sf3", 1'b1, 3'd4, 32'h40, 32'hFFFF_FFFF, 0);
    applyStimulus("keep_20", 1'b0, 3'd2, 32'h20, 32'h0, 0);
    applyStimulus("keep_40", 1'b0, 3'd2, 32'h40, 32'h0, 0);

    applyStimulus("bp_lw20", 1'b0, 3'd2, 32'h20, 32'h0, 5);

    resetDuringOp("rst_write", 1'b1, 3'd2, 32'h30, 32'hCAFE_F00D);
    applyStimulus("lw_30", 1'b0, 3'd2, 32'h30, 32'h0, 0);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) addr = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 15));
      else addr = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
      st = ($urandom_range(0, 9) < 4);
      applyStimulus($sformatf("rand%0d", n), st, 3'($urandom_range(0, 7)), addr,
                    $urandom, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  // Absolute time limit so the run always ends on its own.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: observed no finish, expected finish before time limit");
    $display("%0d/%0d checks passed", passCount, checkCount + 1);
    $fatal(1, "[TB] time limit reached");
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for load/store requests from the core's load/store address and data generator.
- Accepts one request at a time over a valid/ready handshake and owns a word-organised synchronous data RAM.
- Performs byte/half/word stores by read-modify-write, and byte/half/word loads with sign or zero extension.
- Returns read data and an error flag over a valid/ready response channel.

Parameters:
DEPTH, 1024, number of 32-bit words in the internal RAM (power of two, 4..65536)
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be word-aligned

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
req_valid  input  1  request present
req_ready  output  1  responder can accept a request (high only in IDLE)
req_store  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3: loads 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; stores 0 SB, 1 SH, 2 SW
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0])
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts response
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  misaligned, out-of-range or illegal funct3

Behaviour:
- Reset (rst_n=0 at an edge): state to IDLE; resp_valid=0, resp_rdata=0, resp_err=0. req_ready=0 while rst_n=0. RAM contents are not cleared. Reset overrides any in-flight operation, and a write due in that cycle is suppressed.
- Handshakes: a request is accepted on an edge where req_valid & req_ready, and all request fields are latched then. A response completes on an edge where resp_valid & resp_ready. resp_valid, resp_rdata and resp_err stay stable until that edge.
- States: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. On accept, compute err from the latched fields:
  - misaligned: half with addr[0]=1, word with addr[1:0]!=0;
  - out of range: addr < BASE_ADDR, or (addr-BASE_ADDR)>>2 >= DEPTH;
  - illegal funct3: load funct3 in {3,6,7}, store funct3 >= 3.
- IDLE transitions after accept: err -> RESP (rdata=0, err=1, no RAM access); SW -> WRITE; all other legal requests -> READ.
- READ: RAM read of word index (addr-BASE_ADDR)>>2; the data is registered at the end of this cycle.
  - Load -> RESP; rdata = lane selected by addr[1:0] (byte) or addr[1] (half), sign-extended for LB/LH, zero-extended for LBU/LHU, full word for LW.
  - Sub-word store -> WRITE, with merged word = read word with the addressed lane replaced by req_wdata[7:0] or [15:0].
- WRITE: write the full word (SW: req_wdata) or the merged word; then -> RESP with rdata=0, err=0.
- RESP: resp_valid=1; stays until resp_ready; on completion -> IDLE. A new request cannot be accepted in the same edge as response completion (req_ready rises the following cycle).
- Latency, with accept at edge T and resp_ready held high: error -> resp_valid at T+1; LW/LB/LH/LBU/LHU -> T+2; SW -> T+2; SB/SH -> T+3. Throughput is one request per latency+1 cycles.
- Ordering: a load after a store to the same word observes the stored data; there are no hazards because there is a single outstanding request.
- Little-endian lane mapping: byte k = bits [8k+7:8k].

Test Plan:
- Reset with rst_n=0 for 2 cycles mid-READ -> resp_valid=0, state IDLE, req_ready=1 one cycle after rst_n=1; RAM word previously written (0x11223344 at 0x10) still reads 0x11223344.
- SW 0xDEADBEEF @0x20, then LW @0x20 -> resp_rdata=0xDEADBEEF, err=0; SW resp_valid at T+2, LW resp_valid at T+2.
- SB 0x80 @0x23 over 0x00000000, then LB @0x23 -> 0xFFFFFF80; LBU @0x23 -> 0x00000080; LW @0x20 -> 0x80000000; SB resp_valid at T+3.
- SH 0x8001 @0x42 over 0x12345678, then LH @0x42 -> 0xFFFF8001; LHU @0x40 -> 0x00005678; LW @0x40 -> 0x80015678.
- Errors: LW @0x21, SH @0x43, LB @(BASE_ADDR+4*DEPTH), load funct3=3 -> each resp_err=1, rdata=0, resp_valid at T+1, RAM unchanged.
- Backpressure: hold resp_ready=0 for 5 cycles after LW -> resp_valid and resp_rdata stable, req_ready=0, a second req_valid is not accepted until the cycle after response completion.
